// File: rtl/nlo_sched_if.sv
// nlo_sched_if
// Request/response bus between the requesters and the nlo_sched scheduler.
//   master modport : requester side (drives requests, accepts responses)
//   slave modport  : scheduler side (grants requests, returns responses)
// Signals:
//   req_valid [NREQ]       per-requester request valid
//   req_ready [NREQ]       one-hot grant/accept
//   req_op    [3*NREQ]     op code, requester i at [3i+2:3i]
//   req_qin   [WIDTH*NREQ] operand, requester i at [WIDTH*i +: WIDTH]
//   resp_valid/resp_ready  response handshake
//   resp_id   [ID_W]       index of the requester served
//   resp_data [WIDTH]      captured core result, 0 on error
//   resp_err               unsupported op
interface nlo_sched_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_qin;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [WIDTH-1:0]      resp_data;
  logic                  resp_err;

  modport master (
    output req_valid, req_op, req_qin, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_qin, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/nlo_sched.sv
// nlo_sched
// Shares one non_lin_ops core among NREQ requesters. Requests are granted
// round-robin, one operation in flight at a time. The core is held in reset
// (state 0) except while an operation runs; the result is captured from
// core_qout in the cycle the core reaches the op's latency state, and returned
// with the requester's index as tag.
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   bus            nlo_sched_if.slave request/response bus
//   core_reset     high = core parked in state 0
//   core_op/qin    op and operand latched at accept
//   core_qout      core result
//   busy           scheduler not idle
// Optional feature (macro NLO_SCHED_STATS_EN): adds saturating counters
//   stat_ops (32), stat_err (16), stat_busy (32).
module nlo_sched #(
  parameter int WIDTH       = 32,
  parameter int NREQ        = 4,
  parameter int ID_W        = 2,
  parameter int LAT_EXP     = 8,
  parameter int LAT_GELU    = 0,
  parameter int LAT_LN      = 0,
  parameter int LAT_REQUANT = 0,
  parameter int LAT_SMAX    = 0
) (
  input  logic             clock,
  input  logic             reset,
  nlo_sched_if.slave       bus,
  output logic             core_reset,
  output logic [2:0]       core_op,
  output logic [WIDTH-1:0] core_qin,
  input  logic [WIDTH-1:0] core_qout,
  output logic             busy
`ifdef NLO_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [15:0]      stat_err,
  output logic [31:0]      stat_busy
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r, state_n;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [15:0]      cnt_r;
  logic [2:0]       core_op_r;
  logic [WIDTH-1:0] core_qin_r;
  logic [ID_W-1:0]  resp_id_r;
  logic [WIDTH-1:0] resp_data_r;
  logic             resp_err_r;

  logic             grant_found_s;
  logic [ID_W-1:0]  grant_idx_s;
  logic [2:0]       sel_op_s;
  logic [WIDTH-1:0] sel_qin_s;
  logic             accept_s;

  // Latency state of each op; 0 marks the op as unsupported (covers codes > 4).
  function automatic logic [15:0] op_lat(input logic [2:0] op);
    case (op)
      3'd0:    op_lat = 16'(LAT_EXP);
      3'd1:    op_lat = 16'(LAT_GELU);
      3'd2:    op_lat = 16'(LAT_LN);
      3'd3:    op_lat = 16'(LAT_REQUANT);
      3'd4:    op_lat = 16'(LAT_SMAX);
      default: op_lat = 16'd0;
    endcase
  endfunction

  // Round-robin search from rr_ptr, operand mux, next-state and grant decode.
  always_comb begin
    state_n       = state_r;
    grant_found_s = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    sel_op_s      = 3'd0;
    sel_qin_s     = {WIDTH{1'b0}};
    // Outer loop walks priority order; inner loop keeps every bit index constant.
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_found_s && (j == (int'(rr_ptr_r) + i) % NREQ) && bus.req_valid[j]) begin
          grant_found_s = 1'b1;
          grant_idx_s   = ID_W'(j);
        end else begin
          grant_found_s = grant_found_s;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == ID_W'(i)) begin
        sel_op_s  = bus.req_op[3*i +: 3];
        sel_qin_s = bus.req_qin[WIDTH*i +: WIDTH];
      end else begin
        sel_op_s  = sel_op_s;
      end
    end
    accept_s = (state_r == IDLE) && grant_found_s;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = accept_s && (grant_idx_s == ID_W'(i));
    end
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          state_n = (op_lat(sel_op_s) == 16'd0) ? RESP : RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 16'd0) begin
          state_n = RESP;
        end else begin
          state_n = RUN;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pointer, latched request, latency counter and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {ID_W{1'b0}};
      cnt_r       <= 16'd0;
      core_op_r   <= 3'd0;
      core_qin_r  <= {WIDTH{1'b0}};
      resp_id_r   <= {ID_W{1'b0}};
      resp_data_r <= {WIDTH{1'b0}};
      resp_err_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      if (accept_s) begin
        core_op_r  <= sel_op_s;
        core_qin_r <= sel_qin_s;
        resp_id_r  <= grant_idx_s;
        rr_ptr_r   <= ID_W'((int'(grant_idx_s) + 1) % NREQ);
        cnt_r      <= op_lat(sel_op_s);
        if (op_lat(sel_op_s) == 16'd0) begin
          resp_err_r  <= 1'b1;
          resp_data_r <= {WIDTH{1'b0}};
        end else begin
          resp_err_r  <= 1'b0;
        end
      end else if (state_r == RUN) begin
        // cnt reaches 0 exactly when the core sits in the op's latency state.
        if (cnt_r == 16'd0) begin
          resp_data_r <= core_qout;
        end else begin
          cnt_r <= cnt_r - 16'd1;
        end
      end
    end
  end

  assign bus.resp_valid = (state_r == RESP);
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_err   = resp_err_r;
  assign core_reset     = (state_r != RUN);
  assign core_op        = core_op_r;
  assign core_qin       = core_qin_r;
  assign busy           = (state_r != IDLE);

`ifdef NLO_SCHED_STATS_EN
  logic [31:0] stat_ops_r;
  logic [15:0] stat_err_r;
  logic [31:0] stat_busy_r;
  logic        hs_s;

  assign hs_s = bus.resp_valid && bus.resp_ready;

  // Saturating activity counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ops_r  <= 32'd0;
      stat_err_r  <= 16'd0;
      stat_busy_r <= 32'd0;
    end else begin
      if (hs_s && !resp_err_r && (stat_ops_r != 32'hFFFF_FFFF)) begin
        stat_ops_r <= stat_ops_r + 32'd1;
      end
      if (hs_s && resp_err_r && (stat_err_r != 16'hFFFF)) begin
        stat_err_r <= stat_err_r + 16'd1;
      end
      if (busy && (stat_busy_r != 32'hFFFF_FFFF)) begin
        stat_busy_r <= stat_busy_r + 32'd1;
      end
    end
  end

  assign stat_ops  = stat_ops_r;
  assign stat_err  = stat_err_r;
  assign stat_busy = stat_busy_r;
`endif

endmodule

// File: tb/tb_nlo_sched.sv
// tb_nlo_sched
// Directed self-checking bench for nlo_sched (WIDTH=32, NREQ=4, LAT_EXP=8).
// A small core model counts states while core_reset is low and presents
// qin ^ 32'hA5A5_0000 on core_qout only in state 8, so a result captured in
// the wrong cycle is visible.
module tb_nlo_sched;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_reset;
  logic [2:0]  core_op;
  logic [31:0] core_qin;
  logic [31:0] core_qout;
  logic        busy;
  logic [7:0]  core_st;
  logic [2:0]  op_a  [4];
  logic [31:0] qin_a [4];
  int          checks = 0;
  int          errors = 0;
`ifdef NLO_SCHED_STATS_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_err;
  logic [31:0] stat_busy;
`endif

  nlo_sched_if #(.WIDTH(32), .NREQ(4), .ID_W(2)) bus ();

  assign bus.req_op  = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign bus.req_qin = {qin_a[3], qin_a[2], qin_a[1], qin_a[0]};

  nlo_sched #(.WIDTH(32), .NREQ(4), .ID_W(2), .LAT_EXP(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .core_reset (core_reset),
    .core_op    (core_op),
    .core_qin   (core_qin),
    .core_qout  (core_qout),
    .busy       (busy)
`ifdef NLO_SCHED_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_err   (stat_err),
    .stat_busy  (stat_busy)
`endif
  );

  always #5 clock = ~clock;

  // Core model: state counter parked at 0 while core_reset is high.
  always @(posedge clock) begin
    if (core_reset) core_st <= 8'd0;
    else            core_st <= core_st + 8'd1;
  end
  assign core_qout = (core_st == 8'd8) ? (core_qin ^ KEY) : {24'hDEAD00, core_st};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One request from requester idx with resp_ready held high; checks grant,
  // response latency, core_reset low time, tag, data, error and return to idle.
  task automatic do_req(input int idx, input logic [2:0] op, input logic [31:0] qin,
                        input logic exp_err, input logic [31:0] exp_data,
                        input int exp_lat, input string tag);
    int n;
    int low;
    op_a[idx]      = op;
    qin_a[idx]     = qin;
    bus.req_valid  = 4'(1) << idx;
    bus.resp_ready = 1'b1;
    #1;
    check({tag, "_grant"}, 32'(bus.req_ready), 32'(4'(1) << idx));
    tick();
    bus.req_valid = 4'b0000;
    check({tag, "_core_qin"}, core_qin, qin);
    n   = 1;
    low = 0;
    while (!bus.resp_valid && n < 40) begin
      if (!core_reset) low++;
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_core_reset_low"}, 32'(low), 32'(exp_lat - 1));
    check({tag, "_id"}, 32'(bus.resp_id), 32'(idx));
    check({tag, "_data"}, bus.resp_data, exp_data);
    check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, "_core_reset_resp"}, 32'(core_reset), 32'd1);
    tick();
    check({tag, "_idle"}, {30'd0, busy, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    int ng;
    int nr;
    int n;
    int stable;
    reset          = 1'b1;
    bus.req_valid  = 4'b0000;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_a[i]  = 3'd0;
      qin_a[i] = 32'd0;
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    // Reset state
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_core_op", 32'(core_op), 32'd0);
    check("rst_core_qin", core_qin, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single exp
    do_req(0, 3'd0, 32'hFFFF_FF00, 1'b0, 32'h5A5A_FF00, 10, "exp0");

    // Round-robin with all requesters valid, after a reset so rr_ptr is 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_a[i]  = 3'd0;
      qin_a[i] = 32'h0000_0011 * 32'(i + 1);
    end
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    #1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 60 && nr < 5; c++) begin
      if (bus.req_ready != 4'b0000) begin
        check("rr_grant", 32'(bus.req_ready), 32'(4'(1) << (ng % 4)));
        check("rr_spacing", 32'(c), 32'(11 * ng));
        ng++;
      end
      if (bus.resp_valid) begin
        check("rr_id", 32'(bus.resp_id), 32'(nr % 4));
        check("rr_data", bus.resp_data, qin_a[nr % 4] ^ KEY);
        nr++;
      end
      tick();
      if (ng == 5) bus.req_valid = 4'b0000;
      #1;
    end
    check("rr_resp_count", 32'(nr), 32'd5);
    check("rr_idle", 32'(busy), 32'd0);

    // Unsupported op codes
    do_req(2, 3'd5, 32'hCAFE_0001, 1'b1, 32'd0, 1, "unsup5");
    do_req(1, 3'd1, 32'h0000_BEEF, 1'b1, 32'd0, 1, "gelu0");

    // Backpressure
    bus.resp_ready = 1'b0;
    op_a[3]        = 3'd0;
    qin_a[3]       = 32'h1234_5678;
    bus.req_valid  = 4'b1000;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = 4'b0001;
    n = 1;
    while (!bus.resp_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_lat", 32'(n), 32'd10);
    stable = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.resp_valid && bus.resp_id == 2'd3 && bus.resp_data == 32'hB791_5678 &&
          !bus.resp_err && bus.req_ready == 4'b0000 && busy) stable++;
      tick();
    end
    check("bp_stable", 32'(stable), 32'd20);
    bus.req_valid  = 4'b0000;
    bus.resp_ready = 1'b1;
    tick();
    check("bp_idle", {30'd0, busy, bus.resp_valid}, 32'd0);

    // Reset in RUN cycle 4
    op_a[1]       = 3'd0;
    qin_a[1]      = 32'h0F0F_0F0F;
    bus.req_valid = 4'b0010;
    #1;
    check("mr_grant", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) tick();
    check("mr_busy_run", {30'd0, busy, core_reset}, 32'b10);
    reset = 1'b1;
    tick();
    check("mr_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mr_core_reset", 32'(core_reset), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_resp_data", bus.resp_data, 32'd0);
    check("mr_core_qin", core_qin, 32'd0);
    reset = 1'b0;
    do_req(3, 3'd0, 32'h0000_00FF, 1'b0, 32'hA5A5_00FF, 10, "post_rst");

`ifdef NLO_SCHED_STATS_EN
    do_req(0, 3'd0, 32'h0000_1000, 1'b0, 32'hA5A5_1000, 10, "st_a");
    do_req(1, 3'd0, 32'h0000_2000, 1'b0, 32'hA5A5_2000, 10, "st_b");
    do_req(2, 3'd7, 32'h0000_3000, 1'b1, 32'd0, 1, "st_err");
    check("stat_ops", stat_ops, 32'd3);
    check("stat_err", 32'(stat_err), 32'd1);
    check("stat_busy", stat_busy, 32'd31);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
